reg_dump_tx: RTL and testbench



---
 rtl/reg_dump_tx.sv | 71 +++++++
 tb/tb_reg_dump_tx.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/reg_dump_tx.sv
// reg_dump_tx: captures the register-file snapshot on start and streams it as header, data bytes and XOR checksum over valid/ready
module reg_dump_tx #(
  parameter int NUM_REGS = 32,
  parameter int REG_WIDTH = 32,
  parameter logic [7:0] HEADER_BYTE = 8'hA5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [NUM_REGS*REG_WIDTH-1:0] Registros,
  input  logic                          tx_ready,
  output logic [7:0]                    tx_data,
  output logic                          tx_valid,
  output logic                          busy,
  output logic                          done
);
  localparam int W = NUM_REGS * REG_WIDTH;
  localparam int N = W / 8;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, HEADER, DATA, CHECKSUM} state_t;
  state_t state;
  logic [W-1:0] shadow;
  logic [CW-1:0] cnt;
  logic [7:0] csum;
  // frame sequencer; the shadow shifts left so the next data byte is always in its top 8 bits
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      shadow <= '0;
      cnt <= '0;
      csum <= '0;
      tx_data <= '0;
      tx_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          shadow <= Registros;
          csum <= '0;
          cnt <= '0;
          tx_data <= HEADER_BYTE;
          tx_valid <= 1'b1;
          busy <= 1'b1;
          state <= HEADER;
        end
        HEADER: if (tx_ready) begin
          tx_data <= shadow[W-1 -: 8];
          shadow <= shadow << 8;
          cnt <= '0;
          state <= DATA;
        end
        DATA: if (tx_ready) begin
          csum <= csum ^ tx_data;
          cnt <= cnt + 1'b1;
          shadow <= shadow << 8;
          tx_data <= cnt == CW'(N - 1) ? csum ^ tx_data : shadow[W-1 -: 8];
          state <= cnt == CW'(N - 1) ? CHECKSUM : DATA;
        end
        CHECKSUM: if (tx_ready) begin
          tx_valid <= 1'b0;
          busy <= 1'b0;
          done <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_reg_dump_tx.sv
// tb_reg_dump_tx: table-driven frame checks plus hand sequences for stall, isolation, busy start, restart and abort
module tb_reg_dump_tx;
  logic clk = 0, reset = 1, start = 0, tx_ready = 1;
  logic [1023:0] regs = '0;
  logic [7:0] tx_data;
  logic tx_valid, busy, done;
  int nvec = 0, nerr = 0;
  int nb, bad, dc;

  typedef struct {
    string name;
    int pat;
    int stall_at;
    int stall_len;
    int exp_done;
  } vec_t;
  vec_t tbl[4];

  always #5 clk = ~clk;

  reg_dump_tx dut (
    .clk(clk), .reset(reset), .start(start), .Registros(regs),
    .tx_ready(tx_ready), .tx_data(tx_data), .tx_valid(tx_valid),
    .busy(busy), .done(done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1023:0] snap(input int pat);
    logic [1023:0] s = '0;
    for (int k = 0; k < 32; k++) begin
      if (pat == 0 && k == 1) s[1023-32*k -: 32] = 32'hDEADBEEF;
      if (pat == 1) s[1023-32*k -: 32] = 32'(k);
      if (pat == 3 && k == 31) s[1023-32*k -: 32] = 32'h01020304;
    end
    return s;
  endfunction

  function automatic logic [7:0] exp_byte(input int pat, input int i);
    int r, b;
    r = (i - 1) / 4;
    b = (i - 1) % 4;
    if (i == 0) return 8'hA5;
    if (i == 129) return pat == 0 ? 8'h22 : pat == 3 ? 8'h04 : 8'h00;
    case (pat)
      0: if (r == 1) case (b) 0: return 8'hDE; 1: return 8'hAD; 2: return 8'hBE; default: return 8'hEF; endcase
      1: if (b == 3) return 8'(r);
      3: if (r == 31) return 8'(b + 1);
      default: ;
    endcase
    return 8'h00;
  endfunction

  task automatic run_frame(input int pat, input int stall_at, input int stall_len, input int start_at,
                           input int abort_at, input logic clobber,
                           output int nbytes, output int bad_idx, output int done_cyc);
    int cyc = 0, st = 0;
    nbytes = 0;
    bad_idx = -1;
    done_cyc = -1;
    while (cyc < 400) begin
      if (clobber && cyc == 0) regs = '1;
      if (done) begin
        done_cyc = cyc;
        chk("valid_at_done", {31'b0, tx_valid}, 0);
        chk("busy_at_done", {31'b0, busy}, 0);
        break;
      end
      if (nbytes == abort_at) begin
        reset = 1;
        @(negedge clk);
        reset = 0;
        chk("abort_valid", {31'b0, tx_valid}, 0);
        chk("abort_busy", {31'b0, busy}, 0);
        chk("abort_done", {31'b0, done}, 0);
        chk("abort_data", {24'b0, tx_data}, 0);
        break;
      end
      start = nbytes == start_at;
      tx_ready = !(nbytes == stall_at && st < stall_len);
      if (!tx_ready) begin
        st++;
        chk("stall_valid", {31'b0, tx_valid}, 1);
        chk("stall_data", {24'b0, tx_data}, {24'b0, exp_byte(pat, stall_at)});
      end else if (tx_valid) begin
        if (bad_idx < 0 && tx_data !== exp_byte(pat, nbytes)) bad_idx = nbytes;
        nbytes++;
      end
      @(negedge clk);
      cyc++;
    end
    start = 0;
    tx_ready = 1;
    if (done_cyc < 0 && abort_at < 0) chk("frame_timeout", 32'(cyc), 0);
  endtask

  task automatic kick(input int pat);
    regs = snap(pat);
    start = 1;
    @(negedge clk);
    start = 0;
    chk("hdr_valid", {31'b0, tx_valid}, 1);
    chk("hdr_busy", {31'b0, busy}, 1);
  endtask

  task automatic check_frame(input string name, input int exp_done);
    chk({name, "_len"}, 32'(nb), 130);
    chk({name, "_first_bad_byte"}, 32'(bad), 32'hFFFFFFFF);
    chk({name, "_done_cycle"}, 32'(dc), 32'(exp_done));
  endtask

  initial begin
    tbl[0] = '{"framing", 0, -1, 0, 130};
    tbl[1] = '{"backpressure", 0, 5, 5, 135};
    tbl[2] = '{"reg_index", 1, -1, 0, 130};
    tbl[3] = '{"last_reg", 3, -1, 0, 130};
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'b0, tx_valid}, 0);
    chk("rst_data", {24'b0, tx_data}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    reset = 0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      kick(tbl[i].pat);
      run_frame(tbl[i].pat, tbl[i].stall_at, tbl[i].stall_len, -1, -1, 0, nb, bad, dc);
      check_frame(tbl[i].name, tbl[i].exp_done);
      @(negedge clk);
      chk({tbl[i].name, "_done_pulse"}, {31'b0, done}, 0);
    end
    kick(0);
    run_frame(0, -1, 0, -1, -1, 1, nb, bad, dc);
    check_frame("isolation", 130);
    @(negedge clk);
    kick(0);
    run_frame(0, -1, 0, 10, -1, 0, nb, bad, dc);
    check_frame("start_busy", 130);
    repeat (2) begin
      @(negedge clk);
      chk("no_queued_valid", {31'b0, tx_valid}, 0);
      chk("no_queued_busy", {31'b0, busy}, 0);
    end
    kick(0);
    run_frame(0, -1, 0, -1, -1, 0, nb, bad, dc);
    check_frame("pre_restart", 130);
    start = 1;
    @(negedge clk);
    start = 0;
    chk("restart_valid", {31'b0, tx_valid}, 1);
    chk("restart_data", {24'b0, tx_data}, 32'hA5);
    run_frame(0, -1, 0, -1, -1, 0, nb, bad, dc);
    check_frame("restart", 130);
    @(negedge clk);
    kick(0);
    run_frame(0, -1, 0, -1, 50, 0, nb, bad, dc);
    chk("abort_at_byte", 32'(nb), 50);
    @(negedge clk);
    chk("abort_quiet_done", {31'b0, done}, 0);
    kick(1);
    run_frame(1, -1, 0, -1, -1, 0, nb, bad, dc);
    check_frame("after_abort", 130);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
